sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Upstream writer for the framebuffer RAM's write port.
- On a start pulse, copies one player sprite frame from the character RAM into the 240x160 framebuffer at a given position, selected by playerDir.
- Skips transparent-key pixels and clips off-screen pixels.
- Issues one pixel per clock through a two-stage read/write pipeline, so the display stage reads the composited scene.

Parameters:
- SPR_W, 16, sprite width in pixels
- SPR_H, 16, sprite height in pixels
- SCREEN_W, 240, framebuffer width (row stride)
- SCREEN_H, 160, framebuffer height
- TRANSPARENT, 24'hFF00FF, RGB key that is never written

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- spr_x  in  10  signed sprite top-left X in framebuffer pixels; may be negative
- spr_y  in  10  signed sprite top-left Y in framebuffer pixels; may be negative
- playerDir  in  2  sprite frame index (0..3)
- busy  out  1  high from first read cycle through last write cycle
- done  out  1  one-cycle pulse after the last write slot
- Char_addr  out  19  character RAM read address, registered
- Char_data  in  24  character RAM read data; valid the cycle after Char_addr
- FB_addr  out  19  framebuffer write address, registered
- FB_data  out  24  framebuffer write data, registered
- FB_we  out  1  framebuffer write enable, registered

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State goes to IDLE.
  - busy, done, FB_we go to 0; Char_addr, FB_addr, FB_data go to 0.
  - Any in-flight pipeline valid bits are cleared; no write may occur after reset asserts.
  - A blit interrupted by reset is abandoned, not resumed.
- FSM states: IDLE, BLIT, DRAIN.
  - IDLE -> BLIT when start=1. spr_x, spr_y, playerDir are latched and col/row counters are zeroed.
  - BLIT: each cycle presents Char_addr = playerDir*SPR_W*SPR_H + row*SPR_W + col, then advances col. When col wraps at SPR_W-1, col goes to 0 and row increments. After pixel (SPR_H-1, SPR_W-1) the FSM goes to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then IDLE with done=1 for that single cycle.
- start while busy is ignored; it is neither queued nor does it alter the latched parameters.
- Timing, with start sampled at edge T (16x16 sprite):
  - Char_addr for pixels 0..255 appears in cycles T+1..T+256.
  - Char_data is valid in T+2..T+257.
  - FB_we is possible in T+3..T+258.
  - done pulses at T+259.
  - busy is high T+1..T+258 and low at T+259.
  - A new start is accepted at T+259 or later.
- Stage 1 registers are sent alongside each read: pixel valid, on-screen flag, fb address.
  - sx = spr_x+col, sy = spr_y+row, computed 11-bit signed.
  - On-screen iff 0<=sx<SCREEN_W and 0<=sy<SCREEN_H.
  - fb address = sy*SCREEN_W + sx, 19-bit unsigned; computed only when on-screen, otherwise don't-care.
- Stage 2 (write):
  - FB_we = valid & on-screen & (Char_data != TRANSPARENT).
  - FB_data = Char_data; FB_addr = stage-1 address.
  - When FB_we=0, FB_addr and FB_data hold their previous values.
- Fully off-screen sprite: full 256-read sequence, zero writes, done at T+259; timing is identical regardless of clipping.
- Each in-bounds pixel is written at most once per blit; writes occur in raster order.

Decomposition:
- Package pokemon_gfx_pkg:
  - SCREEN_W, SCREEN_H, TRANSPARENT, SPR_W, SPR_H
  - typedef rgb_t (24-bit) and fb_addr_t (19-bit)
  - enum dir_t (DOWN=0, UP=1, LEFT=2, RIGHT=3)
  - blitter state enum
- One sub-module, blit_coord_gen: col/row counters, last-pixel flag, char-address computation.

Test Plan:
- Reset_n=0 during BLIT at pixel 100 -> FB_we=0 immediately, busy=0, no further writes; a subsequent start produces a full 256-read blit.
- start with spr_x=10, spr_y=20, playerDir=0, char RAM of all non-key values -> exactly 256 writes:
  - first write FB_addr=20*240+10=4810, last write 35*240+25=8425;
  - done at T+259; the first Char_addr is 0 at T+1.
- playerDir=2 -> first Char_addr=512 and last Char_addr=767; sprite with 6 pixels equal to 24'hFF00FF -> exactly 250 writes, none carrying that value.
- spr_x=-4, spr_y=152 -> only cols 4..15 and rows 0..7 written (96 writes); the first write is at FB_addr 152*240+0=36480; done still at T+259.
- spr_x=300, spr_y=0 -> zero writes, busy high 258 cycles, done pulses once.
- start re-pulsed at T+50 with different spr_x -> ignored; write addresses match the first request; start at T+259 is accepted.

Source files
------------

// File: rtl/pokemon_gfx_pkg.sv
// Shared graphics constants and types for the framebuffer/character RAM path.
// Also holds the screen-clipping and framebuffer-indexing helpers used by the blitter.
package pokemon_gfx_pkg;

    localparam int SPR_W    = 16;
    localparam int SPR_H    = 16;
    localparam int SCREEN_W = 240;
    localparam int SCREEN_H = 160;
    localparam int COL_W    = $clog2(SPR_W);
    localparam int ROW_W    = $clog2(SPR_H);
    localparam int CHAR_AW  = 19;
    localparam int FB_AW    = 19;
    localparam int CRD_W    = 11;

    typedef logic [23:0]       rgb_t;
    typedef logic [FB_AW-1:0]  fb_addr_t;

    localparam rgb_t TRANSPARENT = 24'hFF00FF;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLIT,
        S_DRAIN
    } blit_state_t;

    function automatic logic on_screen(input logic signed [CRD_W-1:0] x,
                                       input logic signed [CRD_W-1:0] y);
        return !x[CRD_W-1] && (x < CRD_W'(SCREEN_W)) &&
               !y[CRD_W-1] && (y < CRD_W'(SCREEN_H));
    endfunction

    // Only meaningful for on-screen coordinates; the result is ignored otherwise.
    function automatic fb_addr_t fb_index(input logic signed [CRD_W-1:0] x,
                                          input logic signed [CRD_W-1:0] y);
        return fb_addr_t'($unsigned(y)) * fb_addr_t'(SCREEN_W) + fb_addr_t'($unsigned(x));
    endfunction

endpackage

// File: rtl/blit_coord_gen.sv
// Raster walker over one sprite frame: col/row counters, last-pixel flag and
// the character RAM address of the current pixel.
module blit_coord_gen
    import pokemon_gfx_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               clear,
    input  logic               adv,
    input  dir_t               dir,
    output logic [COL_W-1:0]   col,
    output logic [ROW_W-1:0]   row,
    output logic               last,
    output logic [CHAR_AW-1:0] char_addr
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last      = (col == COL_LAST) && (row == ROW_LAST);
    assign char_addr = CHAR_AW'(dir) * CHAR_AW'(SPR_W * SPR_H)
                     + CHAR_AW'(row) * CHAR_AW'(SPR_W)
                     + CHAR_AW'(col);

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite frame from character RAM into the framebuffer, one pixel per
// clock, skipping the transparent key and clipping anything outside the screen.
module sprite_blitter
    import pokemon_gfx_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic signed [9:0]  spr_x,
    input  logic signed [9:0]  spr_y,
    input  logic [1:0]         playerDir,
    output logic               busy,
    output logic               done,
    output logic [CHAR_AW-1:0] Char_addr,
    input  rgb_t               Char_data,
    output fb_addr_t           FB_addr,
    output rgb_t               FB_data,
    output logic               FB_we
);

    blit_state_t             state;
    logic                    drain_cnt;
    logic signed [9:0]       x_lat;
    logic signed [9:0]       y_lat;
    dir_t                    dir_lat;
    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic                    last;
    logic [CHAR_AW-1:0]      char_addr_c;
    logic signed [CRD_W-1:0] sx;
    logic signed [CRD_W-1:0] sy;
    logic                    accept;
    logic                    wr_ok;

    logic                    vld_p1, on_p1;
    fb_addr_t                addr_p1;
    logic                    vld_p2, on_p2;
    fb_addr_t                addr_p2;

    assign accept = (state == S_IDLE) && start;

    blit_coord_gen u_coord (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .clear     (accept),
        .adv       (state == S_BLIT),
        .dir       (dir_lat),
        .col       (col),
        .row       (row),
        .last      (last),
        .char_addr (char_addr_c)
    );

    assign sx    = {x_lat[9], x_lat} + CRD_W'(col);
    assign sy    = {y_lat[9], y_lat} + CRD_W'(row);
    assign wr_ok = vld_p2 && on_p2 && (Char_data != TRANSPARENT);

    // busy/done lag the state by one clock so busy covers the final write slot
    // while a new start can already be taken in the first IDLE cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Char_addr <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            FB_we     <= 1'b0;
            FB_addr   <= '0;
            FB_data   <= '0;
        end else begin
            busy <= (state != S_IDLE);
            done <= (state == S_IDLE) && busy;

            // stage 1: character RAM read issued with its screen metadata
            vld_p1 <= (state == S_BLIT);
            if (state == S_BLIT) Char_addr <= char_addr_c;

            // stage 2: metadata aligned with returning Char_data
            vld_p2 <= vld_p1;

            // write stage
            FB_we <= wr_ok;
            if (wr_ok) begin
                FB_addr <= addr_p2;
                FB_data <= Char_data;
            end

            case (state)
                S_IDLE: begin
                    if (start) state <= S_BLIT;
                end
                S_BLIT: begin
                    if (last) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (accept) begin
            x_lat   <= spr_x;
            y_lat   <= spr_y;
            dir_lat <= dir_t'(playerDir);
        end
        on_p1   <= on_screen(sx, sy);
        addr_p1 <= fb_index(sx, sy);
        on_p2   <= on_p1;
        addr_p2 <= addr_p1;
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a per-blit write list built from the pixel
// rules, checked every cycle, plus literal expectations for each scenario.
module tb_sprite_blitter;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic               start = 1'b0;
    logic signed [9:0]  spr_x = '0;
    logic signed [9:0]  spr_y = '0;
    logic [1:0]         playerDir = '0;
    logic               busy, done;
    logic [18:0]        Char_addr;
    logic [23:0]        Char_data;
    logic [18:0]        FB_addr;
    logic [23:0]        FB_data;
    logic               FB_we;

    sprite_blitter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .playerDir (playerDir),
        .busy      (busy),
        .done      (done),
        .Char_addr (Char_addr),
        .Char_data (Char_data),
        .FB_addr   (FB_addr),
        .FB_data   (FB_data),
        .FB_we     (FB_we)
    );

    always #5 Clk = ~Clk;

    localparam logic [23:0] KEY = 24'hFF00FF;

    logic [23:0] cram [0:1023];
    always @(posedge Clk) Char_data <= cram[Char_addr[9:0]];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [18:0] addr;
        logic [23:0] data;
    } wr_t;
    wr_t wq[$];

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int t_act = -1000;
    int t_prev = -1000;
    int dir_act = 0;
    int last_e = 0;

    int wr_cnt, first_addr, last_addr, key_seen, busy_cnt, done_cnt, done_cyc;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        wr_cnt = 0; first_addr = -1; last_addr = -1; key_seen = 0;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) begin
            @(posedge Clk);
            #2;
        end
    endtask

    // Called 2ns after a rising edge; start is sampled on the next edge E.
    task automatic pulse_start(input int x, input int y, input int dir);
        int e;
        wr_t w;
        e = cyc + 1;
        last_e = e;
        spr_x = 10'(x);
        spr_y = 10'(y);
        playerDir = 2'(dir);
        start = 1'b1;
        if (e >= t_act + 259) begin
            t_prev = t_act;
            t_act = e;
            dir_act = dir;
            for (int k = 0; k < 256; k++) begin
                int sx, sy;
                sx = x + k % 16;
                sy = y + k / 16;
                w.cyc = e + 3 + k;
                w.addr = 19'(sy * 240 + sx);
                w.data = cram[dir * 256 + k];
                if (sx >= 0 && sx < 240 && sy >= 0 && sy < 160 && w.data != KEY)
                    wq.push_back(w);
            end
        end
        @(posedge Clk);
        #2;
        start = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            bit busy_exp, done_exp;
            busy_exp = (cyc >= t_act + 1 && cyc <= t_act + 258) ||
                       (cyc >= t_prev + 1 && cyc <= t_prev + 258);
            done_exp = (cyc == t_act + 259) || (cyc == t_prev + 259);
            check("busy", busy, busy_exp);
            check("done", done, done_exp);
            if (cyc >= t_act + 1 && cyc <= t_act + 256)
                check("char_addr", Char_addr, dir_act * 256 + (cyc - t_act - 1));
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                check("fb_we", FB_we, 1);
                check("fb_addr", FB_addr, wq[0].addr);
                check("fb_data", FB_data, wq[0].data);
                void'(wq.pop_front());
            end else begin
                check("fb_we_idle", FB_we, 0);
            end
            if (FB_we) begin
                wr_cnt++;
                if (first_addr < 0) first_addr = int'(FB_addr);
                last_addr = int'(FB_addr);
                if (FB_data == KEY) key_seen++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) cram[i] = 24'(i * 3 + 1);
        cram[512] = KEY; cram[529] = KEY; cram[612] = KEY;
        cram[712] = KEY; cram[766] = KEY; cram[767] = KEY;
        clear_stats();

        // reset state
        repeat (3) @(posedge Clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fb_we", FB_we, 0);
        check("rst_char_addr", Char_addr, 0);
        check("rst_fb_addr", FB_addr, 0);
        check("rst_fb_data", FB_data, 0);
        Reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge Clk);
        #2;

        // A: on-screen sprite, no key pixels
        clear_stats();
        pulse_start(10, 20, 0);
        t = last_e;
        wait_until(t + 1);
        check("A_first_char_addr", Char_addr, 0);
        wait_until(t + 262);
        check("A_writes", wr_cnt, 256);
        check("A_first_addr", first_addr, 4810);
        check("A_last_addr", last_addr, 8425);
        check("A_done_offset", done_cyc - t, 259);
        check("A_done_cnt", done_cnt, 1);
        check("A_busy_cycles", busy_cnt, 258);

        // B: frame 2 with six key pixels
        clear_stats();
        pulse_start(100, 50, 2);
        t = last_e;
        wait_until(t + 1);
        check("B_first_char_addr", Char_addr, 512);
        wait_until(t + 256);
        check("B_last_char_addr", Char_addr, 767);
        wait_until(t + 262);
        check("B_writes", wr_cnt, 250);
        check("B_key_written", key_seen, 0);

        // C: clipped at left and bottom edges
        clear_stats();
        pulse_start(-4, 152, 3);
        t = last_e;
        wait_until(t + 262);
        check("C_writes", wr_cnt, 96);
        check("C_first_addr", first_addr, 36480);
        check("C_done_offset", done_cyc - t, 259);

        // D: fully off-screen
        clear_stats();
        pulse_start(300, 0, 1);
        t = last_e;
        wait_until(t + 262);
        check("D_writes", wr_cnt, 0);
        check("D_busy_cycles", busy_cnt, 258);
        check("D_done_cnt", done_cnt, 1);

        // E: start while busy is ignored; start at T+259 is taken
        clear_stats();
        pulse_start(10, 20, 0);
        t = last_e;
        wait_until(t + 49);
        pulse_start(50, 60, 1);
        wait_until(t + 258);
        pulse_start(0, 0, 3);
        check("E_first_writes", wr_cnt, 256);
        check("E_first_addr", first_addr, 4810);
        check("E_last_addr", last_addr, 8425);
        clear_stats();
        wait_until(t + 259 + 262);
        check("E_second_writes", wr_cnt, 256);
        check("E_second_first", first_addr, 0);
        check("E_second_last", last_addr, 3615);
        check("E_second_done", done_cyc - t, 259 + 259);

        // F: reset in the middle of a blit
        pulse_start(10, 20, 0);
        t = last_e;
        wait_until(t + 101);
        check("F_char_addr_px100", Char_addr, 100);
        Reset_n = 1'b0;
        wq.delete();
        t_act = -1000;
        t_prev = -1000;
        #1;
        check("F_fb_we_async", FB_we, 0);
        check("F_busy_async", busy, 0);
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        clear_stats();
        wait_until(cyc + 300);
        check("F_no_writes_after_reset", wr_cnt, 0);
        check("F_no_done_after_reset", done_cnt, 0);
        clear_stats();
        pulse_start(0, 0, 0);
        t = last_e;
        wait_until(t + 262);
        check("F_restart_writes", wr_cnt, 256);
        check("F_restart_done", done_cyc - t, 259);
        check("F_model_drained", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
